context_sequencer: RTL and testbench

Generates the read-address stream for the context memory. A run is launched with a start/end address pair. The block drives the memory's PC and read enable for each address in the range, flags the cycles on which the memory's registered output holds a fresh context word, and reports completion with a done pulse. It sits directly upstream of the context memory, on its read port; the write port is owned by the loader.

---
 rtl/context_sequencer_pkg.sv | 15 +
 rtl/context_sequencer.sv | 140 ++++++++++++++
 tb/tb_context_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/context_sequencer_pkg.sv
// Shared definitions for the context-memory read sequencer: address/word widths,
// default repeat-count width and the sequencer state encoding.
package context_sequencer_pkg;

    localparam int CONTEXT_ADDR_WIDTH = 6;
    localparam int CONTEXT_WIDTH      = 32;
    localparam int CONTEXT_LOOP_WIDTH = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_FLUSH = 2'd2
    } seq_state_t;

endpackage

// File: rtl/context_sequencer.sv
// Purpose: walks an inclusive (optionally wrapping) address range on the context memory read port.
// Latency: first read one cycle after launch, data flagged one cycle after each read; DONE with the last VALID.
// Backpressure: STALL_I holds PC and drops EN_O combinationally. Repeat passes need macro CONTEXT_SEQ_LOOP_EN.
module context_sequencer
    import context_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = CONTEXT_ADDR_WIDTH,
    parameter int LOOP_WIDTH = CONTEXT_LOOP_WIDTH
) (
    input  logic                  CLK_I,
    input  logic                  RST_N_I,
    input  logic                  START_I,
    input  logic [ADDR_WIDTH-1:0] START_ADDR_I,
    input  logic [ADDR_WIDTH-1:0] END_ADDR_I,
`ifdef CONTEXT_SEQ_LOOP_EN
    input  logic [LOOP_WIDTH-1:0] LOOP_COUNT_I,
`endif
    input  logic                  STALL_I,
    input  logic                  ABORT_I,
    output logic [ADDR_WIDTH-1:0] PC_O,
    output logic                  EN_O,
    output logic                  VALID_O,
    output logic                  BUSY_O,
    output logic                  DONE_O
);

    seq_state_t            state_q;
    seq_state_t            state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] start_q;
    logic [ADDR_WIDTH-1:0] end_q;
    logic                  valid_q;
    logic                  rd_en;
    logic                  at_end;
    logic                  loop_more;
    logic                  launch;

    assign launch = (state_q == SEQ_IDLE) && START_I;
    assign at_end = (pc_q == end_q);

`ifdef CONTEXT_SEQ_LOOP_EN
    logic [LOOP_WIDTH-1:0] loop_q;

    assign loop_more = (loop_q != '0);

    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            loop_q <= '0;
        end else if (launch) begin
            loop_q <= LOOP_COUNT_I;
        end else if (rd_en && at_end && loop_more) begin
            loop_q <= loop_q - 1'b1;
        end
    end
`else
    // Single-pass build: the repeat count is permanently zero.
    localparam logic [LOOP_WIDTH-1:0] LOOP_NONE = '0;
    assign loop_more = (LOOP_NONE != '0);
`endif

    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort wins over end-of-range; in IDLE it is ignored so a launch always proceeds.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE: begin
                if (START_I) begin
                    state_d = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                if (ABORT_I) begin
                    state_d = SEQ_IDLE;
                end else if (rd_en && at_end && !loop_more) begin
                    state_d = SEQ_FLUSH;
                end
            end
            SEQ_FLUSH: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_en  = 1'b0;
        BUSY_O = 1'b0;
        DONE_O = 1'b0;
        case (state_q)
            SEQ_RUN: begin
                rd_en  = ~STALL_I & ~ABORT_I;
                BUSY_O = 1'b1;
            end
            SEQ_FLUSH: begin
                BUSY_O = 1'b1;
                DONE_O = ~ABORT_I;
            end
            default: begin
                rd_en  = 1'b0;
            end
        endcase
    end

    // A wrap back to start costs no bubble: the reload happens on the same read as the end address.
    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            pc_q    <= '0;
            start_q <= '0;
            end_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en;
            if (launch) begin
                pc_q    <= START_ADDR_I;
                start_q <= START_ADDR_I;
                end_q   <= END_ADDR_I;
            end else if (rd_en) begin
                if (!at_end) begin
                    pc_q <= pc_q + 1'b1;
                end else if (loop_more) begin
                    pc_q <= start_q;
                end
            end
        end
    end

    assign PC_O    = pc_q;
    assign EN_O    = rd_en;
    assign VALID_O = valid_q;

endmodule

// File: tb/tb_context_sequencer.sv
// Directed bench for context_sequencer with a per-cycle reference model and literal trace checks.
// Loop-repeat scenario is exercised when CONTEXT_SEQ_LOOP_EN is defined.
module tb_context_sequencer;

    localparam int AW = 6;
    localparam int LW = 8;
`ifdef CONTEXT_SEQ_LOOP_EN
    localparam bit LOOP_SUPPORTED = 1'b1;
`else
    localparam bit LOOP_SUPPORTED = 1'b0;
`endif

    logic          CLK_I = 1'b0;
    logic          RST_N_I;
    logic          START_I;
    logic [AW-1:0] START_ADDR_I;
    logic [AW-1:0] END_ADDR_I;
`ifdef CONTEXT_SEQ_LOOP_EN
    logic [LW-1:0] LOOP_COUNT_I;
`endif
    logic          STALL_I;
    logic          ABORT_I;
    logic [AW-1:0] PC_O;
    logic          EN_O;
    logic          VALID_O;
    logic          BUSY_O;
    logic          DONE_O;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    context_sequencer #(.ADDR_WIDTH(AW), .LOOP_WIDTH(LW)) dut (
        .CLK_I        (CLK_I),
        .RST_N_I      (RST_N_I),
        .START_I      (START_I),
        .START_ADDR_I (START_ADDR_I),
        .END_ADDR_I   (END_ADDR_I),
`ifdef CONTEXT_SEQ_LOOP_EN
        .LOOP_COUNT_I (LOOP_COUNT_I),
`endif
        .STALL_I      (STALL_I),
        .ABORT_I      (ABORT_I),
        .PC_O         (PC_O),
        .EN_O         (EN_O),
        .VALID_O      (VALID_O),
        .BUSY_O       (BUSY_O),
        .DONE_O       (DONE_O)
    );

    always #5 CLK_I = ~CLK_I;
    always @(posedge CLK_I) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: the run is the list of addresses still to be read.
    bit            chk_on = 1'b0;
    bit            m_run = 1'b0, m_flush = 1'b0, m_valid = 1'b0;
    logic [AW-1:0] m_pc = '0;
    logic [AW-1:0] m_q[$];
    int            req_loops = 0;
    bit            e_en, e_busy, e_done;

    // Trace recorder for the literal checks.
    bit            log_on = 1'b0;
    logic [AW-1:0] pc_log[$];
    logic [15:0]   vhist = '0;
    int            done_cyc = 0;
    int            done_cnt = 0;
    int            launch_cyc = 0;

    always @(negedge CLK_I) begin
        if (DONE_O === 1'b1) done_cnt++;
        if (log_on) begin
            if (EN_O === 1'b1) pc_log.push_back(PC_O);
            vhist = {vhist[14:0], VALID_O};
            if (DONE_O === 1'b1) begin
                done_cyc = cyc;
                log_on   = 1'b0;
            end
        end
        if (chk_on) begin
            e_en   = m_run && !STALL_I && !ABORT_I;
            e_busy = m_run || m_flush;
            e_done = m_flush && !ABORT_I;
            chk("en",    EN_O,    e_en);
            chk("busy",  BUSY_O,  e_busy);
            chk("done",  DONE_O,  e_done);
            chk("valid", VALID_O, m_valid);
            chk("pc",    PC_O,    m_pc);
            if (!RST_N_I) begin
                m_run = 0; m_flush = 0; m_valid = 0; m_pc = '0; m_q.delete();
            end else begin
                m_valid = e_en;
                if (m_flush) begin
                    m_flush = 0;
                end else if (m_run) begin
                    if (ABORT_I) begin
                        m_run = 0;
                        m_q.delete();
                    end else if (e_en) begin
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) begin
                            m_run = 0; m_flush = 1;
                        end else begin
                            m_pc = m_q[0];
                        end
                    end
                end else if (START_I) begin
                    for (int p = 0; p <= (LOOP_SUPPORTED ? req_loops : 0); p++) begin
                        logic [AW-1:0] a;
                        a = START_ADDR_I;
                        for (int k = 0; k < (1 << AW); k++) begin
                            m_q.push_back(a);
                            if (a == END_ADDR_I) break;
                            a = a + 1'b1;
                        end
                    end
                    m_run = 1;
                    m_pc  = m_q[0];
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] e, input int l);
        START_ADDR_I = s;
        END_ADDR_I   = e;
        req_loops    = l;
`ifdef CONTEXT_SEQ_LOOP_EN
        LOOP_COUNT_I = LW'(l);
`endif
        START_I = 1'b1;
        step();
        START_I = 1'b0;
        launch_cyc = cyc;
        pc_log.delete();
        vhist  = '0;
        log_on = 1'b1;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        for (int n = 0; n < 200 && log_on; n++) step();
        if (log_on) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no DONE_O expected one within 200 cycles", name);
            log_on = 1'b0;
        end else begin
            chk({name, "_lat"}, done_cyc - launch_cyc + 1, exp_lat);
        end
        chk({name, "_idle"}, BUSY_O, 1'b0);
    endtask

    task automatic check_log(input string name, input int exp[$]);
        chk({name, "_len"}, pc_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < pc_log.size(); i++)
            chk({name, "_pc"}, pc_log[i], exp[i]);
    endtask

    initial begin
        int exp_q[$];
        int dc;
        RST_N_I = 1'b0; START_I = 1'b0; STALL_I = 1'b0; ABORT_I = 1'b0;
        START_ADDR_I = '0; END_ADDR_I = '0;
`ifdef CONTEXT_SEQ_LOOP_EN
        LOOP_COUNT_I = '0;
`endif
        step();
        chk_on = 1'b1;
        chk("rst_pc", PC_O, 0);
        chk("rst_en", EN_O, 0);
        chk("rst_valid", VALID_O, 0);
        chk("rst_busy", BUSY_O, 0);
        chk("rst_done", DONE_O, 0);
        step();
        RST_N_I = 1'b1;
        step();

        // 4..7, with a stray START mid-run that must be ignored.
        launch(6'd4, 6'd7, 0);
        step();
        START_ADDR_I = 6'd20; END_ADDR_I = 6'd30; START_I = 1'b1;
        step();
        START_I = 1'b0;
        wait_done("r4_7", 5);
        exp_q = '{4, 5, 6, 7};
        check_log("r4_7", exp_q);
        chk("r4_7_valid", vhist[4:0], 5'b01111);

        // Range wrapping through the all-ones address.
        launch(6'h3E, 6'h01, 0);
        wait_done("wrap", 5);
        exp_q = '{'h3E, 'h3F, 'h00, 'h01};
        check_log("wrap", exp_q);

        // Single-word range.
        launch(6'd9, 6'd9, 0);
        wait_done("single", 2);
        exp_q = '{9};
        check_log("single", exp_q);

        // Stall on the 2nd and 3rd RUN cycles.
        launch(6'd0, 6'd3, 0);
        step();
        STALL_I = 1'b1;
        #1;
        chk("stall_pc", PC_O, 1);
        chk("stall_en", EN_O, 0);
        step();
        step();
        STALL_I = 1'b0;
        wait_done("stall", 7);
        exp_q = '{0, 1, 2, 3};
        check_log("stall", exp_q);
        chk("stall_valid", vhist[6:0], 7'b0100111);

`ifdef CONTEXT_SEQ_LOOP_EN
        launch(6'd2, 6'd3, 2);
        wait_done("loop", 7);
        exp_q = '{2, 3, 2, 3, 2, 3};
        check_log("loop", exp_q);
`endif

        // Abort on the 3rd RUN cycle, then relaunch with START and ABORT together.
        dc = done_cnt;
        launch(6'd0, 6'd15, 0);
        step();
        step();
        ABORT_I = 1'b1;
        #1;
        chk("abort_en", EN_O, 0);
        step();
        ABORT_I = 1'b0;
        log_on  = 1'b0;
        chk("abort_busy", BUSY_O, 0);
        chk("abort_pc", PC_O, 2);
        ABORT_I = 1'b1;
        launch(6'd0, 6'd15, 0);
        ABORT_I = 1'b0;
        chk("start_abort_busy", BUSY_O, 1);
        step();
        step();
        step();
        RST_N_I = 1'b0;
        step();
        RST_N_I = 1'b1;
        log_on  = 1'b0;
        chk("mid_rst_pc", PC_O, 0);
        chk("mid_rst_en", EN_O, 0);
        chk("mid_rst_valid", VALID_O, 0);
        chk("mid_rst_busy", BUSY_O, 0);
        chk("mid_rst_done", DONE_O, 0);
        step();
        chk("no_done", done_cnt, dc);

        launch(6'd4, 6'd7, 0);
        wait_done("after_rst", 5);
        exp_q = '{4, 5, 6, 7};
        check_log("after_rst", exp_q);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
        $fatal(1);
    end

endmodule
